ps2_cmd_queue: RTL and testbench

- Parametrised successor to the PS/2 key-to-command stage.
- Consumes scancode bytes from the PS/2 receiver and decodes scan code set 2, including the E0 extended prefix and the F0 break prefix.
- Maps make codes to game commands and queues them in a small FIFO.
- Presents each command on a held output for a programmable time, followed by a mandatory idle gap. Typematic repeat can be suppressed.

---
 rtl/ps2_cmd_queue.sv | 177 +++++++++++++++++
 tb/tb_ps2_cmd_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_queue.sv
// PS/2 set-2 scancode decoder feeding a small command FIFO,
// drained by a hold/gap output sequencer.
module ps2_cmd_queue #(
  parameter int HOLD_CYCLES = 2000000,
  parameter int DEPTH       = 4,
  parameter int REPEAT_EN   = 0,
  parameter int CMD_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  output logic [CMD_W-1:0] command,
  output logic             cmd_start,
  output logic             key_held,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  logic             r_ext;
  logic             r_brk;
  logic [8:0]       r_last_key;
  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [NW-1:0]    r_count;
  logic [CW-1:0]    r_cnt;
  state_t           r_state;

  logic             w_done;
  logic [8:0]       w_key;
  logic [CMD_W-1:0] w_cmd;
  logic             w_repeat;
  logic             w_accept;
  logic             w_brk_hit;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_done = code_valid
               && (code_in != 8'hE0)
               && (code_in != 8'hF0);
  assign w_key  = {r_ext, code_in};

  always_comb begin
    w_cmd = '0;
    case (w_key)
      9'h01B:  w_cmd = CMD_W'(1);
      9'h076:  w_cmd = CMD_W'(2);
      9'h04D:  w_cmd = CMD_W'(3);
      9'h02D:  w_cmd = CMD_W'(4);
      9'h175:  w_cmd = CMD_W'(5);
      9'h174:  w_cmd = CMD_W'(6);
      9'h172:  w_cmd = CMD_W'(7);
      9'h16B:  w_cmd = CMD_W'(8);
      default: w_cmd = '0;
    endcase
  end

  // Typematic repeats of the key still down are dropped unless enabled.
  assign w_repeat  = (REPEAT_EN == 0) && key_held
                  && (w_key == r_last_key);
  assign w_accept  = w_done && !r_brk
                  && (w_cmd != '0) && !w_repeat;
  assign w_brk_hit = w_done && r_brk
                  && (w_key == r_last_key);

  assign w_full = (r_count == FULL);
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_push = w_accept && (!w_full || w_pop);
  assign w_drop = w_accept && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_last_key <= '0;
      key_held   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= w_drop;
      if (code_valid) begin
        if (code_in == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (code_in == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
      if (w_accept) begin
        r_last_key <= w_key;
        key_held   <= 1'b1;
      end else if (w_brk_hit) begin
        key_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      command   <= '0;
      cmd_start <= 1'b0;
    end else begin
      cmd_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            command   <= r_mem[r_rd];
            cmd_start <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_HOLD;
          end else begin
            command <= '0;
          end
        end
        S_HOLD: begin
          if (r_cnt == LAST) begin
            command <= '0;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          command <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cmd_queue.sv
// Directed bench for ps2_cmd_queue: two instances with HOLD_CYCLES=8,
// DEPTH=4, one with repeats suppressed and one with repeats enabled.
module tb_ps2_cmd_queue;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] code_in;
  logic       code_valid;
  logic [3:0] cmd0, cmd1;
  logic       st0, st1, kh0, kh1, ov0, ov1;

  int nchk = 0;
  int nfail = 0;

  int q_cmd0[$], q_run0[$], q_gap0[$];
  int q_cmd1[$], q_run1[$], q_gap1[$];
  int run0, run1, z0, z1, n_ovf0, n_ovf1;
  bit seen0, seen1;
  int exp_q[$];

  always #5 clk = ~clk;

  ps2_cmd_queue #(
    .HOLD_CYCLES(8), .DEPTH(4), .REPEAT_EN(0), .CMD_W(4)
  ) u_dut (
    .clk(clk), .reset(reset),
    .code_in(code_in), .code_valid(code_valid),
    .command(cmd0), .cmd_start(st0),
    .key_held(kh0), .overflow(ov0)
  );

  ps2_cmd_queue #(
    .HOLD_CYCLES(8), .DEPTH(4), .REPEAT_EN(1), .CMD_W(4)
  ) u_rep (
    .clk(clk), .reset(reset),
    .code_in(code_in), .code_valid(code_valid),
    .command(cmd1), .cmd_start(st1),
    .key_held(kh1), .overflow(ov1)
  );

  // Observe outputs on the falling edge: starts, run lengths, gaps.
  always @(negedge clk) begin
    if (st0) q_cmd0.push_back(int'(cmd0));
    if (st1) q_cmd1.push_back(int'(cmd1));
    if (ov0) n_ovf0++;
    if (ov1) n_ovf1++;
    if (cmd0 != 4'd0) begin
      if (seen0 && z0 != 0) q_gap0.push_back(z0);
      z0 = 0; run0++; seen0 = 1'b1;
    end else begin
      if (run0 != 0) q_run0.push_back(run0);
      run0 = 0;
      if (seen0) z0++;
    end
    if (cmd1 != 4'd0) begin
      if (seen1 && z1 != 0) q_gap1.push_back(z1);
      z1 = 0; run1++; seen1 = 1'b1;
    end else begin
      if (run1 != 0) q_run1.push_back(run1);
      run1 = 0;
      if (seen1) z1++;
    end
  end

  task automatic clear_mon();
    q_cmd0.delete(); q_run0.delete(); q_gap0.delete();
    q_cmd1.delete(); q_run1.delete(); q_gap1.delete();
    run0 = 0; run1 = 0; z0 = 0; z1 = 0;
    n_ovf0 = 0; n_ovf1 = 0;
    seen0 = 1'b0; seen1 = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    code_in    = b;
    code_valid = 1'b1;
    tick(1);
    code_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int q[$],
                       input int e[$]);
    chk({tag, ".size"}, q.size(), e.size());
    for (int i = 0; i < q.size() && i < e.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), q[i], e[i]);
  endtask

  initial begin
    reset      = 1'b1;
    code_in    = 8'h00;
    code_valid = 1'b0;
    clear_mon();
    tick(2);
    chk("rst.command", cmd0, 0);
    chk("rst.cmd_start", st0, 0);
    chk("rst.key_held", kh0, 0);
    chk("rst.overflow", ov0, 0);
    reset = 1'b0;
    tick(2);

    // Make, hold, break of the start key
    clear_mon();
    send(8'h1B);
    chk("t1.key_held_make", kh0, 1);
    chk("t1.cmd_t1", cmd0, 0);
    tick(1);
    chk("t1.cmd_t2", cmd0, 1);
    chk("t1.start_t2", st0, 1);
    send(8'hF0);
    chk("t1.start_t3", st0, 0);
    send(8'h1B);
    chk("t1.key_held_brk", kh0, 0);
    tick(12);
    exp_q = '{1};
    chk_q("t1.cmds", q_cmd0, exp_q);
    exp_q = '{8};
    chk_q("t1.runs", q_run0, exp_q);

    // Extended up arrow, its break, then a bare keypad 75
    clear_mon();
    send(8'hE0);
    send(8'h75);
    chk("t2.key_held_make", kh0, 1);
    tick(1);
    chk("t2.cmd", cmd0, 5);
    chk("t2.start", st0, 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t2.key_held_brk", kh0, 0);
    send(8'h75);
    chk("t2.key_held_kp", kh0, 0);
    tick(14);
    exp_q = '{5};
    chk_q("t2.cmds", q_cmd0, exp_q);
    chk("t2.idle", cmd0, 0);

    // Typematic repeat: suppressed vs enabled
    clear_mon();
    send(8'h1B);
    send(8'h1B);
    send(8'h1B);
    tick(40);
    exp_q = '{1};
    chk_q("t3.norep.cmds", q_cmd0, exp_q);
    exp_q = '{1, 1, 1};
    chk_q("t3.rep.cmds", q_cmd1, exp_q);
    exp_q = '{8, 8, 8};
    chk_q("t3.rep.runs", q_run1, exp_q);
    exp_q = '{2, 2};
    chk_q("t3.rep.gaps", q_gap1, exp_q);
    send(8'hF0);
    send(8'h1B);
    chk("t3.released", kh0, 0);

    // Burst of six makes while the first is holding
    clear_mon();
    send(8'h1B);
    send(8'h76);
    send(8'h4D);
    send(8'h2D);
    send(8'hE0);
    send(8'h74);
    send(8'hE0);
    chk("t4.no_ovf_early", ov0, 0);
    send(8'h72);
    chk("t4.ovf_pulse", ov0, 1);
    chk("t4.key_held", kh0, 1);
    tick(56);
    exp_q = '{1, 2, 3, 4, 6};
    chk_q("t4.cmds", q_cmd0, exp_q);
    exp_q = '{8, 8, 8, 8, 8};
    chk_q("t4.runs", q_run0, exp_q);
    exp_q = '{2, 2, 2, 2};
    chk_q("t4.gaps", q_gap0, exp_q);
    chk("t4.ovf_count", n_ovf0, 1);
    send(8'hF0);
    send(8'hE0);
    send(8'h72);
    chk("t4.released", kh0, 0);

    // Unmapped makes push nothing and leave last_key alone
    clear_mon();
    send(8'h1C);
    send(8'hE0);
    send(8'h1B);
    tick(3);
    chk("t5.cmd", cmd0, 0);
    chk("t5.key_held", kh0, 0);
    chk("t5.n_cmds", q_cmd0.size(), 0);
    send(8'h1B);
    send(8'h1C);
    send(8'hE0);
    send(8'h1B);
    chk("t5.still_held", kh0, 1);
    send(8'hF0);
    send(8'h1B);
    chk("t5.brk_last_key", kh0, 0);
    tick(14);
    exp_q = '{1};
    chk_q("t5.cmds", q_cmd0, exp_q);

    // Asynchronous reset in the middle of a hold, two entries queued
    clear_mon();
    send(8'h1B);
    send(8'h76);
    send(8'h4D);
    tick(2);
    chk("t6.pre.cmd", cmd0, 1);
    chk("t6.pre.key_held", kh0, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6.rst.cmd", cmd0, 0);
    chk("t6.rst.key_held", kh0, 0);
    chk("t6.rst.start", st0, 0);
    chk("t6.rst.ovf", ov0, 0);
    tick(2);
    reset = 1'b0;
    clear_mon();
    tick(20);
    chk("t6.post.cmd", cmd0, 0);
    chk("t6.post.n_cmds", q_cmd0.size(), 0);
    send(8'h2D);
    tick(1);
    chk("t6.new.cmd", cmd0, 4);
    chk("t6.new.start", st0, 1);
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
